ntm_write_heads_controller: RTL and testbench
=============================================

Name: ntm_write_heads_controller

Overview:
- Sequencer for the NTM write-heads accelerator, which computes M_out[j][k] = M_in[j][k] + w[j]*a[k].
- Fetches w, a and M from 1-cycle-latency source memories and streams them to the accelerator with correctly aligned J/K/W/A enables.
- Captures the streamed M_OUT into an output memory and reports completion to the host sequencer.

Parameters:
- DATA_SIZE, 64, width of data words, sizes and indices.
- CONTROL_SIZE, 4, width of the error/status code.

Ports:
- CLK in 1: single clock.
- RST in 1: asynchronous reset, active-low.
- START in 1: host start pulse.
- READY out 1: one-cycle completion pulse.
- SIZE_N_IN in DATA_SIZE: number of rows N.
- SIZE_W_IN in DATA_SIZE: row width W.
- STATUS out CONTROL_SIZE: sticky error code, cleared on accepted START.
- W_ADDR out DATA_SIZE: read address j into the w memory.
- A_ADDR out DATA_SIZE: read address k into the a memory.
- M_ADDR_J, M_ADDR_K out DATA_SIZE each: read address (j,k) into the M memory.
- W_RDATA, A_RDATA, M_RDATA in DATA_SIZE each: read data, valid the cycle after the address.
- ACCEL_START out 1: accelerator start pulse.
- ACCEL_READY in 1: accelerator done pulse.
- ACCEL_SIZE_N, ACCEL_SIZE_W out DATA_SIZE: latched sizes.
- ACCEL_W_IN_ENABLE, ACCEL_A_IN_ENABLE, ACCEL_M_IN_J_ENABLE, ACCEL_M_IN_K_ENABLE out 1: input stream strobes.
- ACCEL_W_IN, ACCEL_A_IN, ACCEL_M_IN out DATA_SIZE: input stream data.
- ACCEL_M_OUT_J_ENABLE, ACCEL_M_OUT_K_ENABLE in 1: output stream strobes.
- ACCEL_M_OUT in DATA_SIZE: output stream data.
- OUT_WE out 1: output memory write enable.
- OUT_ADDR_J, OUT_ADDR_K out DATA_SIZE: output memory write address.
- OUT_WDATA out DATA_SIZE: output memory write data.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; every output 0; all counters 0; STATUS=0.
- FSM states: IDLE, ARM, FETCH_W, FETCH_M, DRAIN, DONE.
- IDLE:
  - START=1 latches SIZE_N_IN/SIZE_W_IN, clears STATUS and goes to ARM.
  - If either size is 0: STATUS=1, go directly to DONE, no accelerator activity.
- ARM: ACCEL_START=1 for exactly one cycle; j=0, k=0; next state FETCH_W.
- FETCH_W (1 cycle): W_ADDR=j; next state FETCH_M.
- FETCH_M (W cycles): M_ADDR_J=j, M_ADDR_K=k, A_ADDR=k.
  - k increments each cycle.
  - At k=W-1: k wraps to 0 and j increments. Next state is FETCH_W if j<N-1, else DRAIN.
- Read alignment (all strobes registered one cycle after their address, data taken straight from RDATA):
  - ACCEL_W_IN_ENABLE / ACCEL_W_IN follow the FETCH_W address by one cycle.
  - ACCEL_M_IN_K_ENABLE and ACCEL_A_IN_ENABLE follow every FETCH_M cycle.
  - ACCEL_M_IN_J_ENABLE accompanies only the k=0 element of each row.
- Input stream length: exactly N W-strobes and N*W K-strobes. One run costs N*(W+1) cycles of FETCH plus the drain.
- Output capture (any state except IDLE):
  - Each ACCEL_M_OUT_K_ENABLE produces, one cycle later, OUT_WE=1, OUT_WDATA=ACCEL_M_OUT, OUT_ADDR=(oj,ok).
  - ok increments and wraps at W-1, at which point oj increments.
  - ACCEL_M_OUT_J_ENABLE with ok!=0 sets STATUS=2 (row misalignment); capture continues.
- DRAIN: exit to DONE when out count = N*W and ACCEL_READY has been seen (in either order; ACCEL_READY is latched in a sticky flag).
- Extra outputs:
  - K-strobes beyond N*W set STATUS=3 and are not written.
  - ACCEL_READY before the count reaches N*W is held and is not an error.
- DONE: READY=1 for one cycle, then IDLE.
- START while not IDLE is ignored.
- Same-cycle START and RST=0: reset wins.
- Reset mid-run: immediate IDLE; no residual strobes.
- Counters are DATA_SIZE wide. N*W is compared via row/column counters, never a product, so there is no overflow.

Test Plan:
- N=2, W=3, w={2,3}, a={1,1,1}, M all 5, accelerator model adds w*a -> streams 2 W-strobes and 6 K-strobes, J-strobes at k=0 only; output writes (0,0..2)=7, (1,0..2)=8; READY after 2*(3+1)+drain cycles; STATUS=0.
- N=1, W=1 -> exactly one ACCEL_START, one W-strobe, one K-strobe with J-strobe; one output write; READY once.
- SIZE_W_IN=0 with START -> no ACCEL_START, READY pulse 2 cycles later, STATUS=1.
- Accelerator model asserts ACCEL_READY before the last output, then 1 extra K-strobe -> READY only after the 6th write; 7th strobe not written; STATUS=3.
- RST low during FETCH_M at j=1,k=1 -> all outputs 0 asynchronously. A new START with N=2, W=2 completes cleanly with 4 writes.
- START pulsed mid-run and ACCEL_M_OUT_J_ENABLE injected at ok=1 -> START ignored (single ACCEL_START); STATUS=2 at READY.

Source files
------------

// File: rtl/ntm_write_heads_controller.sv
`default_nettype none
// ============================================================================
// Module   : ntm_write_heads_controller
// Purpose  : Streams w/a/M into the NTM write-heads accelerator and captures M_OUT.
// Revision : 1.0
// ============================================================================
module ntm_write_heads_controller #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [DATA_SIZE-1:0]    SIZE_N_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_W_IN,
  output logic [CONTROL_SIZE-1:0] STATUS,
  output logic [DATA_SIZE-1:0]    W_ADDR,
  output logic [DATA_SIZE-1:0]    A_ADDR,
  output logic [DATA_SIZE-1:0]    M_ADDR_J,
  output logic [DATA_SIZE-1:0]    M_ADDR_K,
  input  logic [DATA_SIZE-1:0]    W_RDATA,
  input  logic [DATA_SIZE-1:0]    A_RDATA,
  input  logic [DATA_SIZE-1:0]    M_RDATA,
  output logic                    ACCEL_START,
  input  logic                    ACCEL_READY,
  output logic [DATA_SIZE-1:0]    ACCEL_SIZE_N,
  output logic [DATA_SIZE-1:0]    ACCEL_SIZE_W,
  output logic                    ACCEL_W_IN_ENABLE,
  output logic                    ACCEL_A_IN_ENABLE,
  output logic                    ACCEL_M_IN_J_ENABLE,
  output logic                    ACCEL_M_IN_K_ENABLE,
  output logic [DATA_SIZE-1:0]    ACCEL_W_IN,
  output logic [DATA_SIZE-1:0]    ACCEL_A_IN,
  output logic [DATA_SIZE-1:0]    ACCEL_M_IN,
  input  logic                    ACCEL_M_OUT_J_ENABLE,
  input  logic                    ACCEL_M_OUT_K_ENABLE,
  input  logic [DATA_SIZE-1:0]    ACCEL_M_OUT,
  output logic                    OUT_WE,
  output logic [DATA_SIZE-1:0]    OUT_ADDR_J,
  output logic [DATA_SIZE-1:0]    OUT_ADDR_K,
  output logic [DATA_SIZE-1:0]    OUT_WDATA
);

  localparam logic [DATA_SIZE-1:0]    c_one      = DATA_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] c_st_ok    = CONTROL_SIZE'(0);
  localparam logic [CONTROL_SIZE-1:0] c_st_size  = CONTROL_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] c_st_row   = CONTROL_SIZE'(2);
  localparam logic [CONTROL_SIZE-1:0] c_st_extra = CONTROL_SIZE'(3);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_FETCH_W = 3'd2,
    S_FETCH_M = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_accel_start;

  logic [DATA_SIZE-1:0]    r_size_n;
  logic [DATA_SIZE-1:0]    r_size_w;
  logic [DATA_SIZE-1:0]    r_j;
  logic [DATA_SIZE-1:0]    r_k;
  logic [DATA_SIZE-1:0]    r_oj;
  logic [DATA_SIZE-1:0]    r_ok;
  logic                    r_out_done;
  logic                    r_accel_done;
  logic [CONTROL_SIZE-1:0] r_status;
  logic                    r_ready;
  logic                    r_w_en;
  logic                    r_k_en;
  logic                    r_mj_en;
  logic                    r_out_we;
  logic [DATA_SIZE-1:0]    r_out_aj;
  logic [DATA_SIZE-1:0]    r_out_ak;
  logic [DATA_SIZE-1:0]    r_out_wdata;

  logic w_size_zero;
  logic w_k_last;
  logic w_j_last;
  logic w_ok_last;
  logic w_oj_last;

  assign w_size_zero = (SIZE_N_IN == '0) || (SIZE_W_IN == '0);
  assign w_k_last    = (r_k  == r_size_w - c_one);
  assign w_j_last    = (r_j  == r_size_n - c_one);
  assign w_ok_last   = (r_ok == r_size_w - c_one);
  assign w_oj_last   = (r_oj == r_size_n - c_one);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accel_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = w_size_zero ? S_DONE : S_ARM;
      end
      S_ARM: begin
        w_accel_start = 1'b1;
        w_next        = S_FETCH_W;
      end
      S_FETCH_W: w_next = S_FETCH_M;
      S_FETCH_M: begin
        if (w_k_last) w_next = w_j_last ? S_DRAIN : S_FETCH_W;
      end
      S_DRAIN: begin
        // The accelerator may finish before or after the last captured word.
        if (r_out_done && (r_accel_done || ACCEL_READY)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_size_n     <= '0;
      r_size_w     <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_oj         <= '0;
      r_ok         <= '0;
      r_out_done   <= 1'b0;
      r_accel_done <= 1'b0;
      r_status     <= c_st_ok;
      r_ready      <= 1'b0;
      r_w_en       <= 1'b0;
      r_k_en       <= 1'b0;
      r_mj_en      <= 1'b0;
      r_out_we     <= 1'b0;
      r_out_aj     <= '0;
      r_out_ak     <= '0;
      r_out_wdata  <= '0;
    end else begin
      // Strobes trail their address by the one-cycle source-memory latency.
      r_ready  <= (r_state == S_DONE);
      r_w_en   <= (r_state == S_FETCH_W);
      r_k_en   <= (r_state == S_FETCH_M);
      r_mj_en  <= (r_state == S_FETCH_M) && (r_k == '0);
      r_out_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_size_n     <= SIZE_N_IN;
            r_size_w     <= SIZE_W_IN;
            r_status     <= w_size_zero ? c_st_size : c_st_ok;
            r_oj         <= '0;
            r_ok         <= '0;
            r_out_done   <= 1'b0;
            r_accel_done <= 1'b0;
          end
        end
        S_ARM: begin
          r_j <= '0;
          r_k <= '0;
        end
        S_FETCH_M: begin
          if (w_k_last) begin
            r_k <= '0;
            r_j <= r_j + c_one;
          end else begin
            r_k <= r_k + c_one;
          end
        end
        default: ;
      endcase

      if (r_state != S_IDLE) begin
        if (ACCEL_READY) r_accel_done <= 1'b1;
        if (ACCEL_M_OUT_J_ENABLE && (r_ok != '0)) r_status <= c_st_row;
        if (ACCEL_M_OUT_K_ENABLE) begin
          if (r_out_done) begin
            r_status <= c_st_extra;
          end else begin
            r_out_we    <= 1'b1;
            r_out_wdata <= ACCEL_M_OUT;
            r_out_aj    <= r_oj;
            r_out_ak    <= r_ok;
            if (w_ok_last) begin
              r_ok <= '0;
              r_oj <= r_oj + c_one;
              if (w_oj_last) r_out_done <= 1'b1;
            end else begin
              r_ok <= r_ok + c_one;
            end
          end
        end
      end
    end
  end

  assign READY               = r_ready;
  assign STATUS              = r_status;
  assign W_ADDR              = r_j;
  assign A_ADDR              = r_k;
  assign M_ADDR_J            = r_j;
  assign M_ADDR_K            = r_k;
  assign ACCEL_START         = w_accel_start;
  assign ACCEL_SIZE_N        = r_size_n;
  assign ACCEL_SIZE_W        = r_size_w;
  assign ACCEL_W_IN_ENABLE   = r_w_en;
  assign ACCEL_A_IN_ENABLE   = r_k_en;
  assign ACCEL_M_IN_J_ENABLE = r_mj_en;
  assign ACCEL_M_IN_K_ENABLE = r_k_en;
  assign ACCEL_W_IN          = r_w_en ? W_RDATA : '0;
  assign ACCEL_A_IN          = r_k_en ? A_RDATA : '0;
  assign ACCEL_M_IN          = r_k_en ? M_RDATA : '0;
  assign OUT_WE              = r_out_we;
  assign OUT_ADDR_J          = r_out_aj;
  assign OUT_ADDR_K          = r_out_ak;
  assign OUT_WDATA           = r_out_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ntm_write_heads_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntm_write_heads_controller
// Purpose  : Randomized bench with source memories, accelerator and result model.
// Revision : 1.0
// ============================================================================
module tb_ntm_write_heads_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic [63:0] size_n_in = '0;
  logic [63:0] size_w_in = '0;
  logic [3:0]  status;
  logic [63:0] w_addr, a_addr, m_addr_j, m_addr_k;
  logic [63:0] w_rdata = '0, a_rdata = '0, m_rdata = '0;
  logic        accel_start;
  logic        accel_ready = 1'b0;
  logic [63:0] accel_size_n, accel_size_w;
  logic        acc_w_en, acc_a_en, acc_mj_en, acc_mk_en;
  logic [63:0] acc_w_in, acc_a_in, acc_m_in;
  logic        mo_j_en = 1'b0, mo_k_en = 1'b0;
  logic [63:0] m_out = '0;
  logic        out_we;
  logic [63:0] out_addr_j, out_addr_k, out_wdata;

  ntm_write_heads_controller #(.DATA_SIZE(64), .CONTROL_SIZE(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .READY(ready),
    .SIZE_N_IN(size_n_in), .SIZE_W_IN(size_w_in), .STATUS(status),
    .W_ADDR(w_addr), .A_ADDR(a_addr), .M_ADDR_J(m_addr_j), .M_ADDR_K(m_addr_k),
    .W_RDATA(w_rdata), .A_RDATA(a_rdata), .M_RDATA(m_rdata),
    .ACCEL_START(accel_start), .ACCEL_READY(accel_ready),
    .ACCEL_SIZE_N(accel_size_n), .ACCEL_SIZE_W(accel_size_w),
    .ACCEL_W_IN_ENABLE(acc_w_en), .ACCEL_A_IN_ENABLE(acc_a_en),
    .ACCEL_M_IN_J_ENABLE(acc_mj_en), .ACCEL_M_IN_K_ENABLE(acc_mk_en),
    .ACCEL_W_IN(acc_w_in), .ACCEL_A_IN(acc_a_in), .ACCEL_M_IN(acc_m_in),
    .ACCEL_M_OUT_J_ENABLE(mo_j_en), .ACCEL_M_OUT_K_ENABLE(mo_k_en),
    .ACCEL_M_OUT(m_out),
    .OUT_WE(out_we), .OUT_ADDR_J(out_addr_j), .OUT_ADDR_K(out_addr_k),
    .OUT_WDATA(out_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source memories with one-cycle read latency.
  logic [63:0] w_mem [8];
  logic [63:0] a_mem [8];
  logic [63:0] m_mem [8][8];

  always @(posedge clk) begin
    w_rdata <= (w_addr < 64'd8) ? w_mem[w_addr[2:0]] : '0;
    a_rdata <= (a_addr < 64'd8) ? a_mem[a_addr[2:0]] : '0;
    m_rdata <= (m_addr_j < 64'd8 && m_addr_k < 64'd8) ? m_mem[m_addr_j[2:0]][m_addr_k[2:0]] : '0;
  end

  // Accelerator model: consumes the input streams, emits M + w*a with random gaps.
  int          run_n = 1, run_w = 1;
  bit          f_early = 0, f_extra = 0, f_jinj = 0;
  logic [63:0] aq [$];
  logic [63:0] cur_w = '0;
  int          emit_idx = 0, w_strb = 0, k_strb = 0, j_strb = 0, strb_bad = 0;
  bit          active = 0, ready_sent = 0, extra_sent = 0;

  always @(negedge clk) begin : accel_model
    int total;
    mo_k_en     = 1'b0;
    mo_j_en     = 1'b0;
    accel_ready = 1'b0;
    m_out       = '0;
    if (!rst) begin
      aq.delete();
      active = 0;
    end else begin
      total = run_n * run_w;
      if (accel_start) begin
        aq.delete();
        emit_idx = 0; w_strb = 0; k_strb = 0; j_strb = 0; strb_bad = 0;
        active = 1; ready_sent = 0; extra_sent = 0; cur_w = '0;
      end
      if (acc_w_en) begin
        cur_w = acc_w_in;
        w_strb++;
      end
      if (acc_mj_en) j_strb++;
      if (acc_a_en != acc_mk_en) strb_bad++;
      if (acc_mk_en) begin
        if (acc_mj_en != ((k_strb % run_w) == 0)) strb_bad++;
        aq.push_back(acc_m_in + cur_w * acc_a_in);
        k_strb++;
      end else if (acc_mj_en) begin
        strb_bad++;
      end
      if (active) begin
        if (f_extra && emit_idx == total && !extra_sent) begin
          mo_k_en    = 1'b1;
          m_out      = 64'hDEAD_BEEF;
          extra_sent = 1;
        end else if (aq.size() > 0 && $urandom_range(3) != 0) begin
          m_out    = aq.pop_front();
          mo_k_en  = 1'b1;
          mo_j_en  = ((emit_idx % run_w) == 0) || (f_jinj && emit_idx == 1);
          emit_idx++;
        end
        if (!ready_sent && (f_early ? (emit_idx == total - 1) : (emit_idx == total))) begin
          accel_ready = 1'b1;
          ready_sent  = 1;
        end
        if (ready_sent && emit_idx == total && (!f_extra || extra_sent)) active = 0;
      end
    end
  end

  // Output-side monitor.
  typedef struct packed {
    logic [63:0] j;
    logic [63:0] k;
    logic [63:0] d;
  } wr_t;
  wr_t wr_log [$];
  int  start_cnt = 0;
  int  ready_cnt = 0;

  always @(negedge clk) begin
    wr_t e;
    if (out_we) begin
      e.j = out_addr_j;
      e.k = out_addr_k;
      e.d = out_wdata;
      wr_log.push_back(e);
    end
    if (accel_start) start_cnt++;
    if (ready) ready_cnt++;
  end

  logic [63:0] last_out [8][8];

  task automatic fill_random();
    for (int j = 0; j < 8; j++) begin
      w_mem[j] = 64'($urandom);
      a_mem[j] = 64'($urandom);
      for (int k = 0; k < 8; k++) m_mem[j][k] = 64'($urandom);
    end
  endtask

  task automatic do_run(input string tag, input int n, input int w, input bit early,
                        input bit extra, input bit jinj, input bit midstart,
                        input logic [3:0] exp_st);
    int base_start, base_ready, base_wr, lat, errs, total;
    bit seen;
    bit got_bit [8][8];
    wr_t e;
    total = n * w;
    run_n = (n > 0) ? n : 1;
    run_w = (w > 0) ? w : 1;
    f_early = early; f_extra = extra; f_jinj = jinj;
    base_start = start_cnt;
    base_ready = ready_cnt;
    base_wr    = wr_log.size();
    size_n_in  = 64'(n);
    size_w_in  = 64'(w);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    seen  = 0;
    while (!seen && lat < 3000) begin
      if (ready) begin
        seen = 1;
      end else begin
        if (midstart) begin
          start     = (lat == 4);
          size_n_in = (lat == 4) ? 64'd1 : 64'(n);
        end
        @(negedge clk);
        lat++;
      end
    end
    start     = 1'b0;
    size_n_in = 64'(n);
    chk({tag, " ready_seen"}, 64'(seen), 64'd1);
    if (total == 0) chk({tag, " ready_latency"}, 64'(lat), 64'd2);
    chk({tag, " writes_at_ready"}, 64'(wr_log.size() - base_wr), 64'(total));
    repeat (4) @(negedge clk);
    chk({tag, " accel_starts"}, 64'(start_cnt - base_start), (total == 0) ? 64'd0 : 64'd1);
    chk({tag, " ready_pulses"}, 64'(ready_cnt - base_ready), 64'd1);
    chk({tag, " status"}, 64'(status), 64'(exp_st));
    chk({tag, " writes"}, 64'(wr_log.size() - base_wr), 64'(total));
    errs = 0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++) got_bit[j][k] = 0;
    for (int i = base_wr; i < wr_log.size(); i++) begin
      e = wr_log[i];
      if (e.j >= 64'(n) || e.k >= 64'(w) || got_bit[e.j[2:0]][e.k[2:0]]) begin
        errs++;
      end else begin
        got_bit[e.j[2:0]][e.k[2:0]] = 1;
        last_out[e.j[2:0]][e.k[2:0]] = e.d;
        if (e.d !== m_mem[e.j[2:0]][e.k[2:0]] + w_mem[e.j[2:0]] * a_mem[e.k[2:0]]) errs++;
      end
    end
    chk({tag, " data_errors"}, 64'(errs), 64'd0);
    if (total > 0) begin
      chk({tag, " w_strobes"}, 64'(w_strb), 64'(n));
      chk({tag, " k_strobes"}, 64'(k_strb), 64'(total));
      chk({tag, " j_strobes"}, 64'(j_strb), 64'(n));
      chk({tag, " strobe_align"}, 64'(strb_bad), 64'd0);
      chk({tag, " size_n_latched"}, accel_size_n, 64'(n));
    end
  endtask

  initial begin
    int found;
    fill_random();
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset status", 64'(status), 64'd0);
    chk("reset outputs", 64'(|{accel_start, out_we, acc_w_en, acc_mk_en, w_addr, m_addr_k}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed example: w={2,3}, a=1, M=5.
    w_mem[0] = 64'd2;
    w_mem[1] = 64'd3;
    for (int k = 0; k < 8; k++) begin
      a_mem[k] = 64'd1;
      m_mem[0][k] = 64'd5;
      m_mem[1][k] = 64'd5;
    end
    do_run("n2w3", 2, 3, 0, 0, 0, 0, 4'd0);
    chk("n2w3 out00", last_out[0][0], 64'd7);
    chk("n2w3 out02", last_out[0][2], 64'd7);
    chk("n2w3 out10", last_out[1][0], 64'd8);
    chk("n2w3 out12", last_out[1][2], 64'd8);

    fill_random();
    do_run("n1w1", 1, 1, 0, 0, 0, 0, 4'd0);
    do_run("w_zero", 2, 0, 0, 0, 0, 0, 4'd1);
    do_run("n_zero", 0, 3, 0, 0, 0, 0, 4'd1);
    fill_random();
    do_run("early_extra", 2, 3, 1, 1, 0, 0, 4'd3);

    // Asynchronous reset in the middle of FETCH_M at (1,1).
    fill_random();
    run_n = 2; run_w = 3; f_early = 0; f_extra = 0; f_jinj = 0;
    size_n_in = 64'd2;
    size_w_in = 64'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (m_addr_j == 64'd1 && m_addr_k == 64'd1) found = 1;
      else @(negedge clk);
    end
    chk("midrst reached_j1k1", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst outputs_zero",
        64'(|{ready, status, w_addr, a_addr, m_addr_j, m_addr_k, accel_start,
              accel_size_n, accel_size_w, acc_w_en, acc_a_en, acc_mj_en, acc_mk_en,
              acc_w_in, acc_a_in, acc_m_in, out_we, out_addr_j, out_addr_k, out_wdata}),
        64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_run("after_rst", 2, 2, 0, 0, 0, 0, 4'd0);

    fill_random();
    do_run("midstart_jinj", 2, 3, 0, 0, 1, 1, 4'd2);

    for (int i = 0; i < 6; i++) begin
      int rn, rw;
      rn = $urandom_range(1, 4);
      rw = $urandom_range(1, 4);
      fill_random();
      do_run($sformatf("rand%0d", i), rn, rw, 1'($urandom_range(1)), 0, 0, 0, 4'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
